// File: rtl/game_pkg.sv
// Shared constants, colours and FSM encoding for the projectile game datapath.
package game_pkg;

    // Fixed-point fraction width for position and velocity (Q.6).
    localparam int unsigned FRAC_W = 6;

    // VGA adapter resolution.
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StDrawPix,
        StWaitFrame,
        StErase,
        StUpdate,
        StCheck,
        StWin,
        StLose
    } state_e;

    // cos(10 + 10*idx degrees) in Q1.6; sin(idx) is cos_q6(7 - idx).
    function automatic logic [5:0] cos_q6(input logic [2:0] idx);
        case (idx)
            3'd0:    cos_q6 = 6'd63;
            3'd1:    cos_q6 = 6'd60;
            3'd2:    cos_q6 = 6'd55;
            3'd3:    cos_q6 = 6'd49;
            3'd4:    cos_q6 = 6'd41;
            3'd5:    cos_q6 = 6'd32;
            3'd6:    cos_q6 = 6'd22;
            default: cos_q6 = 6'd11;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Physics-step timer: counts FRAME_CYCLES enabled cycles and pulses tick on the last one.
module frame_tick #(
    parameter int unsigned FRAME_CYCLES = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntLast);

    // Next count: clear wins, wrap to zero on the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/projectile_engine.sv
// Projectile flight datapath: launch, per-frame erase/update/redraw, and win/lose detection.
module projectile_engine
    import game_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned LAUNCH_X     = 10,
    parameter int unsigned GROUND_Y     = 110,
    parameter int unsigned GRAVITY      = 4,
    parameter int unsigned TARGET_W     = 8,
    parameter int unsigned SCREEN_W     = game_pkg::SCREEN_W,
    parameter logic [2:0]  COLOUR       = WHITE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_en,
    input  logic [2:0] angle,
    input  logic [2:0] strength,
    input  logic [7:0] target_x,
    output logic       plot,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       win,
    output logic       lose
);

    localparam logic [14:0] LaunchXQ   = 15'(LAUNCH_X << FRAC_W);
    localparam logic [8:0]  GroundY9   = 9'(GROUND_Y);
    localparam logic [8:0]  ScreenW9   = 9'(SCREEN_W);
    localparam logic [8:0]  TargetSpan = 9'(TARGET_W - 1);
    localparam logic [10:0] Gravity11  = 11'(GRAVITY);

    state_e             state_q, state_d;
    logic        [14:0] x_q, x_d;    // Q9.6, unsigned
    logic signed [14:0] h_q, h_d;    // Q8.6 height above ground
    logic        [9:0]  vx_q, vx_d;
    logic signed [10:0] vy_q, vy_d;
    logic               last_vis_q, last_vis_d;  // last draw actually reached the screen
    logic               plot_q, plot_d;
    logic        [7:0]  plot_x_q, plot_x_d;
    logic        [6:0]  plot_y_q, plot_y_d;
    logic        [2:0]  plot_colour_q, plot_colour_d;
    logic               win_q, win_d, lose_q, lose_d;

    logic       tick, frame_clear;
    logic [8:0] x_int, h_int;
    logic       hit, vis;

    frame_tick #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == StWaitFrame),
        .clear(frame_clear),
        .tick (tick)
    );

    assign x_int = x_q[14:6];
    assign hit   = (x_int >= {1'b0, target_x}) && (x_int <= {1'b0, target_x} + TargetSpan);

    // Next state and physics registers.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        if (state_q != StIdle && !draw_en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:      if (draw_en) state_d = StLoad;
                StLoad: begin
                    x_d     = LaunchXQ;
                    h_d     = '0;
                    vx_d    = 10'(strength) * 10'(cos_q6(angle));
                    vy_d    = $signed(11'(strength) * 11'(cos_q6(3'd7 - angle)));
                    state_d = StDrawPix;
                end
                StDrawPix:   state_d = StWaitFrame;
                StWaitFrame: if (tick) state_d = StErase;
                StErase:     state_d = StUpdate;
                StUpdate: begin
                    x_d     = x_q + {5'd0, vx_q};
                    h_d     = h_q + {{4{vy_q[10]}}, vy_q};
                    vy_d    = vy_q - $signed(Gravity11);
                    state_d = StCheck;
                end
                StCheck: begin
                    if (h_q[14]) begin
                        state_d = hit ? StWin : StLose;
                    end else if (x_int >= ScreenW9) begin
                        state_d = StLose;
                    end else begin
                        state_d = StDrawPix;
                    end
                end
                StWin, StLose: state_d = state_q;
                default:       state_d = StIdle;
            endcase
        end
    end

    assign frame_clear = (state_q == StLoad) || (state_d == StIdle);
    assign h_int       = h_d[14:6];
    assign vis         = (h_int <= GroundY9);

    // Registered outputs decoded from the state being entered.
    always_comb begin
        plot_d        = 1'b0;
        plot_x_d      = plot_x_q;
        plot_y_d      = plot_y_q;
        plot_colour_d = plot_colour_q;
        last_vis_d    = last_vis_q;
        if (state_d == StDrawPix) begin
            last_vis_d = vis;
            if (vis) begin
                plot_d        = 1'b1;
                plot_x_d      = x_d[13:6];
                plot_y_d      = 7'(GroundY9 - h_int);
                plot_colour_d = COLOUR;
            end
        end else if (state_d == StErase && last_vis_q) begin
            plot_d        = 1'b1;
            plot_colour_d = BLACK;
        end
        win_d  = (state_d == StWin);
        lose_d = (state_d == StLose);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            x_q           <= '0;
            h_q           <= '0;
            vx_q          <= '0;
            vy_q          <= '0;
            last_vis_q    <= 1'b0;
            plot_q        <= 1'b0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            h_q           <= h_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            last_vis_q    <= last_vis_d;
            plot_q        <= plot_d;
            plot_x_q      <= plot_x_d;
            plot_y_q      <= plot_y_d;
            plot_colour_q <= plot_colour_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign plot        = plot_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_colour_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_projectile_engine.sv
// Directed bench for projectile_engine with a 4-cycle physics step.
module tb_projectile_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       draw_en;
    logic [2:0] angle;
    logic [2:0] strength;
    logic [7:0] target_x;
    logic       plot;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       win;
    logic       lose;

    int total = 0;
    int bad   = 0;

    projectile_engine #(
        .FRAME_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .draw_en    (draw_en),
        .angle      (angle),
        .strength   (strength),
        .target_x   (target_x),
        .plot       (plot),
        .plot_x     (plot_x),
        .plot_y     (plot_y),
        .plot_colour(plot_colour),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    // Steps negedges until the next plot strobe; n = cycles stepped, found = 0 on timeout.
    task automatic wait_plot(input int max, output int n, output bit found);
        found = 0;
        n     = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            n++;
            if (plot) begin
                found = 1;
                break;
            end
        end
    endtask

    // Runs until win or lose, recording white plots and any plot beyond column 159.
    task automatic run_flight(input int max, output int n_white, output int last_x,
                              output int last_y, output bit wide_x);
        n_white = 0;
        last_x  = -1;
        last_y  = -1;
        wide_x  = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (plot) begin
                if (plot_x > 8'd159) wide_x = 1;
                if (plot_colour == 3'b111) begin
                    n_white++;
                    last_x = plot_x;
                    last_y = plot_y;
                end
            end
            if (win || lose) break;
        end
    endtask

    task automatic launch(input logic [2:0] a, input logic [2:0] s, input logic [7:0] t);
        angle    = a;
        strength = s;
        target_x = t;
        draw_en  = 1'b1;
    endtask

    task automatic stop_flight();
        draw_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        draw_en  = 1'b0;
        angle    = 3'd0;
        strength = 3'd0;
        target_x = 8'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({plot, plot_x, plot_y, plot_colour, win, lose} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got plot=%0b x=%0d y=%0d c=%0d win=%0b lose=%0b want all 0",
                     plot, plot_x, plot_y, plot_colour, win, lose);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (plot !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_plot: got plot=%0b want 0", plot);
        end
    endtask

    task automatic test_launch_angle4();
        int  n;
        bit  found;
        launch(3'd4, 3'd7, 8'd200);
        @(negedge clk);
        total++;
        if (plot !== 1'b0) begin
            bad++;
            $display("FAIL latency_cycle1: got plot=%0b want 0", plot);
        end
        @(negedge clk);
        total++;
        if ({plot, plot_x, plot_y, plot_colour} !== {1'b1, 8'd10, 7'd110, 3'b111}) begin
            bad++;
            $display("FAIL launch_plot: got plot=%0b (%0d,%0d) c=%0d want 1 (10,110) c=7",
                     plot, plot_x, plot_y, plot_colour);
        end
        // Must be ignored after LOAD.
        angle    = 3'd0;
        strength = 3'd1;
        wait_plot(20, n, found);
        total++;
        if (!found || n != 5 || {plot_x, plot_y, plot_colour} !== {8'd10, 7'd110, 3'b000}) begin
            bad++;
            $display("FAIL erase_frame0: got found=%0b after %0d (%0d,%0d) c=%0d want 5 (10,110) c=0",
                     found, n, plot_x, plot_y, plot_colour);
        end
        wait_plot(20, n, found);
        total++;
        // vx=287, vy=343: x=640+287=927 -> 14, h=343 -> 5 -> row 105.
        if (!found || n != 3 || {plot_x, plot_y, plot_colour} !== {8'd14, 7'd105, 3'b111}) begin
            bad++;
            $display("FAIL draw_frame1: got found=%0b after %0d (%0d,%0d) c=%0d want 3 (14,105) c=7",
                     found, n, plot_x, plot_y, plot_colour);
        end
        wait_plot(20, n, found);
        wait_plot(20, n, found);
        total++;
        // vy decremented to 339: x=1214 -> 18, h=682 -> 10 -> row 100.
        if (!found || {plot_x, plot_y, plot_colour} !== {8'd18, 7'd100, 3'b111}) begin
            bad++;
            $display("FAIL draw_frame2: got found=%0b (%0d,%0d) c=%0d want (18,100) c=7",
                     found, plot_x, plot_y, plot_colour);
        end
        stop_flight();
    endtask

    task automatic test_offscreen();
        int nw, lx, ly;
        bit wide;
        // vx=441, vy=77: x_int reaches 160 after frame 22 while h=770 is still positive.
        launch(3'd0, 3'd7, 8'd200);
        run_flight(600, nw, lx, ly, wide);
        total++;
        if ({win, lose} !== 2'b01) begin
            bad++;
            $display("FAIL offscreen_lose: got win=%0b lose=%0b want 0 1", win, lose);
        end
        total++;
        if (nw != 22 || lx != 154 || ly != 98 || wide) begin
            bad++;
            $display("FAIL offscreen_path: got draws=%0d last=(%0d,%0d) wide=%0b want 22 (154,98) 0",
                     nw, lx, ly, wide);
        end
        repeat (10) @(negedge clk);
        total++;
        if ({win, lose, plot} !== 3'b010) begin
            bad++;
            $display("FAIL lose_held: got win=%0b lose=%0b plot=%0b want 0 1 0", win, lose, plot);
        end
        draw_en = 1'b0;
        @(negedge clk);
        total++;
        if ({win, lose} !== 2'b00) begin
            bad++;
            $display("FAIL lose_clear: got win=%0b lose=%0b want 0 0", win, lose);
        end
        @(negedge clk);
    endtask

    task automatic test_strength0();
        int nw, lx, ly;
        bit wide;
        // h stays 0 after frame 1, goes to -4 after frame 2; lands at column 10.
        launch(3'd3, 3'd0, 8'd6);
        run_flight(200, nw, lx, ly, wide);
        total++;
        if ({win, lose} !== 2'b10 || nw != 2 || lx != 10 || ly != 110) begin
            bad++;
            $display("FAIL drop_win: got win=%0b lose=%0b draws=%0d last=(%0d,%0d) want 1 0 2 (10,110)",
                     win, lose, nw, lx, ly);
        end
        stop_flight();
        launch(3'd3, 3'd0, 8'd11);
        run_flight(200, nw, lx, ly, wide);
        total++;
        if ({win, lose} !== 2'b01) begin
            bad++;
            $display("FAIL drop_lose: got win=%0b lose=%0b want 0 1", win, lose);
        end
        stop_flight();
    endtask

    task automatic test_landing_window();
        int nw, lx, ly;
        bit wide;
        logic [7:0] tgt [4];
        logic [1:0] exp_wl [4];
        // angle=2 strength=1: vx=55, vy=32; h first negative at frame 18, x=1630 -> L=25.
        tgt[0] = 8'd18; exp_wl[0] = 2'b10;
        tgt[1] = 8'd17; exp_wl[1] = 2'b01;
        tgt[2] = 8'd25; exp_wl[2] = 2'b10;
        tgt[3] = 8'd26; exp_wl[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            launch(3'd2, 3'd1, tgt[i]);
            run_flight(400, nw, lx, ly, wide);
            total++;
            if ({win, lose} !== exp_wl[i]) begin
                bad++;
                $display("FAIL landing_t%0d: got win=%0b lose=%0b want %02b",
                         tgt[i], win, lose, exp_wl[i]);
            end
            stop_flight();
        end
        // strength=5 leaves the screen after frame 35 long before it could land.
        launch(3'd2, 3'd5, 8'd0);
        run_flight(600, nw, lx, ly, wide);
        total++;
        if ({win, lose} !== 2'b01 || lx != 156 || ly != 61) begin
            bad++;
            $display("FAIL a2s5_offscreen: got win=%0b lose=%0b last=(%0d,%0d) want 0 1 (156,61)",
                     win, lose, lx, ly);
        end
        stop_flight();
    endtask

    task automatic test_drop_mid();
        int  n;
        bit  found;
        launch(3'd4, 3'd7, 8'd0);
        repeat (4) @(negedge clk);  // two cycles into WAIT_FRAME
        draw_en = 1'b0;
        @(negedge clk);
        total++;
        if ({plot, win, lose} !== 3'b000) begin
            bad++;
            $display("FAIL drop_idle: got plot=%0b win=%0b lose=%0b want 0 0 0", plot, win, lose);
        end
        wait_plot(20, n, found);
        total++;
        if (found) begin
            bad++;
            $display("FAIL drop_no_erase: got a plot after %0d cycles want none", n);
        end
        draw_en = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({plot, plot_x, plot_y, plot_colour} !== {1'b1, 8'd10, 7'd110, 3'b111}) begin
            bad++;
            $display("FAIL relaunch_plot: got plot=%0b (%0d,%0d) c=%0d want 1 (10,110) c=7",
                     plot, plot_x, plot_y, plot_colour);
        end
        stop_flight();
    endtask

    task automatic test_reset_mid_flight();
        int  n;
        bit  found;
        launch(3'd4, 3'd7, 8'd0);
        repeat (3) @(negedge clk);  // in WAIT_FRAME, plot_x still holds 10
        reset = 1'b1;
        #1;
        total++;
        if ({plot, plot_x, win, lose} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: got plot=%0b x=%0d win=%0b lose=%0b want all 0",
                     plot, plot_x, win, lose);
        end
        draw_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_plot(15, n, found);
        total++;
        if (found) begin
            bad++;
            $display("FAIL reset_no_plot: got a plot after %0d cycles want none", n);
        end
        draw_en = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({plot, plot_x, plot_y} !== {1'b1, 8'd10, 7'd110}) begin
            bad++;
            $display("FAIL reset_relaunch: got plot=%0b (%0d,%0d) want 1 (10,110)",
                     plot, plot_x, plot_y);
        end
        stop_flight();
    endtask

    initial begin
        test_reset();
        test_launch_angle4();
        test_offscreen();
        test_strength0();
        test_landing_window();
        test_drop_mid();
        test_reset_mid_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
